reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural register file for the SEQ Y86-64 core.
- Read side: decode stage. Write side: commits results produced in the write-back stage.
- Derives srcA/srcB/dstE/dstM from icode/rA/rB/cnd, supplies valA/valB combinationally, and commits valE/valM on the clock edge.
- Holds all fifteen program registers; the only stateful element on the register path.

Parameters:
- WIDTH, 64, data width of each register.
- NREGS, 15, number of architectural registers (IDs 0..14).
- RSP_ID, 4, register ID of %rsp.
- RNONE, 15, "no register" ID.

Ports:
- clk  input  1  core clock; all writes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- icode  input  4  instruction code of the current instruction.
- rA  input  4  rA field from fetch.
- rB  input  4  rB field from fetch.
- cnd  input  1  condition outcome from execute (used for cmovxx).
- valE  input  WIDTH  ALU result to commit.
- valM  input  WIDTH  memory read result to commit.
- wb_en  input  1  commit strobe; low = no writes this cycle (stall / bubble).
- valA  output  WIDTH  read data for srcA.
- valB  output  WIDTH  read data for srcB.
- srcA, srcB, dstE, dstM  output  4 each  selected register IDs (for hazard/debug use).
- dbg_sel  input  4  debug read select.
- dbg_data  output  WIDTH  contents of register dbg_sel (0 if dbg_sel = RNONE).

Behaviour:
- Reset (rst_n low, asynchronous): all 15 registers cleared to 0 immediately. Clear holds while rst_n is low. Outputs reflect the zeroed file: valA = valB = dbg_data = 0. ID outputs are purely combinational from the inputs.
- srcA:
  - icode 2 (rrmovq/cmovxx), 4 (rmmovq), 6 (OPq), A (pushq) -> rA.
  - icode 9 (ret), B (popq) -> RSP_ID.
  - otherwise RNONE.
- srcB:
  - icode 4, 5 (mrmovq), 6 -> rB.
  - icode 8 (call), 9, A, B -> RSP_ID.
  - otherwise RNONE.
- dstE:
  - icode 2 -> rB if cnd = 1, else RNONE.
  - icode 3 (irmovq), 6 -> rB.
  - icode 8, 9, A, B -> RSP_ID.
  - otherwise RNONE.
- dstM: icode 5, B -> rA; otherwise RNONE.
- Reads are combinational; zero latency.
  - Read of RNONE returns 0.
  - An out-of-range rA/rB of 15 naturally maps to RNONE.
- Writes at rising clk when wb_en = 1 and rst_n = 1:
  - reg[dstE] <= valE if dstE != RNONE.
  - reg[dstM] <= valM if dstM != RNONE.
- Same-cycle dstE == dstM (popq %rsp): the valM write wins; %rsp = popped value.
- Read during write to the same register: valA/valB show the old value until the edge; no bypass.
- wb_en = 0: file unchanged; reads still valid.
- Reset asserted mid-cycle with wb_en high: the clear wins and no write occurs. The first write after release happens at the first rising edge with rst_n high.
- Unknown icodes (C..F) and icodes 0, 1, 7: all IDs = RNONE, no writes.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: I_HALT..I_POPQ.
  - RSP_ID, RNONE.
  - WIDTH.
- One combinational sub-module, reg_sel, maps icode/rA/rB/cnd to srcA/srcB/dstE/dstM.
- reg_file instantiates reg_sel plus the storage array and write logic.

Test Plan:
- Reset then read: pulse rst_n low, then icode=6, rA=2, rB=3 -> valA=0, valB=0, srcA=2, srcB=3.
- irmovq commit: icode=3, rB=1, valE=0x1234, wb_en=1, one edge; then icode=6, rA=1 -> valA=0x1234; other registers still 0.
- cmov not taken: icode=2, rA=1, rB=5, cnd=0, valE=0xAA, wb_en=1 -> dstE=RNONE, reg5 stays 0. Repeat with cnd=1 -> reg5=0xAA after the edge.
- popq %rsp: preset %rsp=0x100; icode=B, rA=4, valE=0x108, valM=0xDEAD, wb_en=1 -> after the edge dbg_sel=4 gives 0xDEAD.
- Stall and read-before-write: valE=0x55, dstE=3 (icode=6, rB=3), wb_en=0 -> reg3 unchanged over 3 edges. With wb_en=1, valB shows old value before the edge and 0x55 after.
- Async reset mid-run: registers non-zero, drop rst_n between edges -> dbg_data=0 with no clock edge. Hold wb_en=1 through reset release -> no write until the first edge with rst_n high.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and datapath width.
package y86_pkg;

  localparam int WIDTH = 64;
  localparam int NREGS = 15;

  localparam logic [3:0] RSP_ID = 4'h4;
  localparam logic [3:0] RNONE  = 4'hF;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/reg_sel.sv
// Decode-stage register ID selection: maps icode/rA/rB/cnd onto source and destination IDs.
module reg_sel
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  input  logic [3:0] ra_i,
  input  logic [3:0] rb_i,
  input  logic       cnd_i,
  output logic [3:0] src_a_o,
  output logic [3:0] src_b_o,
  output logic [3:0] dst_e_o,
  output logic [3:0] dst_m_o
);

  always_comb begin
    src_a_o = RNONE;
    src_b_o = RNONE;
    dst_e_o = RNONE;
    dst_m_o = RNONE;
    case (icode_i)
      I_RRMOVQ: begin
        src_a_o = ra_i;
        // cmovxx with a false condition must not disturb rB
        dst_e_o = cnd_i ? rb_i : RNONE;
      end
      I_IRMOVQ: dst_e_o = rb_i;
      I_RMMOVQ: begin
        src_a_o = ra_i;
        src_b_o = rb_i;
      end
      I_MRMOVQ: begin
        src_b_o = rb_i;
        dst_m_o = ra_i;
      end
      I_OPQ: begin
        src_a_o = ra_i;
        src_b_o = rb_i;
        dst_e_o = rb_i;
      end
      I_CALL: begin
        src_b_o = RSP_ID;
        dst_e_o = RSP_ID;
      end
      I_RET: begin
        src_a_o = RSP_ID;
        src_b_o = RSP_ID;
        dst_e_o = RSP_ID;
      end
      I_PUSHQ: begin
        src_a_o = ra_i;
        src_b_o = RSP_ID;
        dst_e_o = RSP_ID;
      end
      I_POPQ: begin
        src_a_o = RSP_ID;
        src_b_o = RSP_ID;
        dst_e_o = RSP_ID;
        dst_m_o = ra_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// SEQ Y86-64 architectural register file: combinational reads, valE/valM commit on the clock.
module reg_file
  import y86_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cnd,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  input  logic             wb_en,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic [3:0]       srcA,
  output logic [3:0]       srcB,
  output logic [3:0]       dstE,
  output logic [3:0]       dstM,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  reg_sel u_reg_sel (
    .icode_i (icode),
    .ra_i    (rA),
    .rb_i    (rB),
    .cnd_i   (cnd),
    .src_a_o (srcA),
    .src_b_o (srcB),
    .dst_e_o (dstE),
    .dst_m_o (dstM)
  );

  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      if (dstE != RNONE) regs_d[dstE] = valE;
      // valM is applied last so popq %rsp leaves the popped value in %rsp
      if (dstM != RNONE) regs_d[dstM] = valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    valA     = (srcA    == RNONE) ? '0 : regs_q[srcA];
    valB     = (srcB    == RNONE) ? '0 : regs_q[srcB];
    dbg_data = (dbg_sel == RNONE) ? '0 : regs_q[dbg_sel];
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an array model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, rA, rB, dbg_sel;
  logic        cnd, wb_en;
  logic [63:0] valE, valM, valA, valB, dbg_data;
  logic [3:0]  srcA, srcB, dstE, dstM;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mdl [15];

  reg_file dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
    .valE(valE), .valM(valM), .wb_en(wb_en), .valA(valA), .valB(valB),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mread(input logic [3:0] id);
    return (id == 4'hF) ? 64'd0 : mdl[id];
  endfunction

  // Expected IDs straight from the instruction semantics table
  function automatic void exp_ids(input logic [3:0] ic, a, b, input logic c,
                                  output logic [3:0] sa, sb, de, dm);
    sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = a;
    else if (ic inside {4'h9, 4'hB})       sa = 4'h4;
    if (ic inside {4'h4, 4'h5, 4'h6})       sb = b;
    else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) sb = 4'h4;
    if ((ic == 4'h2 && c) || ic inside {4'h3, 4'h6}) de = b;
    else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB})     de = 4'h4;
    if (ic inside {4'h5, 4'hB}) dm = a;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 15; i++) mdl[i] = 64'd0;
  endtask

  // Applies one instruction, checks decode/read outputs before the edge, then commits the model.
  task automatic step(input logic [3:0] ic, a, b, input logic c,
                      input logic [63:0] e, m, input logic w);
    logic [3:0] sa, sb, de, dm;
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m; wb_en = w;
    #1;
    exp_ids(ic, a, b, c, sa, sb, de, dm);
    check("srcA", {60'd0, srcA}, {60'd0, sa});
    check("srcB", {60'd0, srcB}, {60'd0, sb});
    check("dstE", {60'd0, dstE}, {60'd0, de});
    check("dstM", {60'd0, dstM}, {60'd0, dm});
    check("valA", valA, mread(sa));
    check("valB", valB, mread(sb));
    @(posedge clk); #1;
    if (w) begin
      if (de != 4'hF) mdl[de] = e;
      if (dm != 4'hF) mdl[dm] = m;
    end
    wb_en = 1'b0;
  endtask

  task automatic check_file();
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      check($sformatf("dbg%0d", i), dbg_data, mread(4'(i)));
    end
  endtask

  task automatic check_reg(input string tag, input logic [3:0] id, input logic [63:0] exp);
    dbg_sel = id;
    #1;
    check(tag, dbg_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    valE = '0; valM = '0; wb_en = 1'b0; dbg_sel = 4'h0;
    clear_model();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_file();

    step(4'h6, 4'h2, 4'h3, 1'b0, 64'd0, 64'd0, 1'b0);
    step(4'h3, 4'hF, 4'h1, 1'b0, 64'h1234, 64'd0, 1'b1);
    step(4'h6, 4'h1, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    check_reg("irmovq_r1", 4'h1, 64'h1234);
    check_reg("irmovq_r2", 4'h2, 64'h0);

    step(4'h2, 4'h1, 4'h5, 1'b0, 64'hAA, 64'd0, 1'b1);
    check_reg("cmov_nt_r5", 4'h5, 64'h0);
    step(4'h2, 4'h1, 4'h5, 1'b1, 64'hAA, 64'd0, 1'b1);
    check_reg("cmov_t_r5", 4'h5, 64'hAA);

    step(4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'd0, 1'b1);
    step(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hDEAD, 1'b1);
    check_reg("popq_rsp", 4'h4, 64'hDEAD);

    for (int k = 0; k < 3; k++) step(4'h6, 4'h3, 4'h3, 1'b0, 64'h55, 64'd0, 1'b0);
    check_reg("stall_r3", 4'h3, 64'h0);
    step(4'h6, 4'h3, 4'h3, 1'b0, 64'h55, 64'd0, 1'b1);
    check_reg("wb_r3", 4'h3, 64'h55);
    check_file();

    icode = 4'h3; rB = 4'h2; valE = 64'h77; wb_en = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reg("async_clr_r1", 4'h1, 64'h0);
    check_reg("async_clr_r4", 4'h4, 64'h0);
    clear_model();
    @(posedge clk); #1;
    check_reg("rst_hold_r2", 4'h2, 64'h0);
    #3 rst_n = 1'b1;
    #1;
    check_reg("rel_nowr_r2", 4'h2, 64'h0);
    @(posedge clk); #1;
    check_reg("rel_wr_r2", 4'h2, 64'h77);
    mdl[2] = 64'h77;
    wb_en = 1'b0;
    check_file();

    for (int k = 0; k < 300; k++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
      if (k % 50 == 49) check_file();
    end
    check_file();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
